// File: rtl/swd_target_responder.sv
// -----------------------------------------------------------------------------
// swd_target_responder
//
// Target-side responder for the SWD wire protocol. It decodes the 8-bit host
// request, returns a 3-bit ACK, and then either drives 32 read-data bits plus
// parity or samples 32 write-data bits plus parity. swclk and swdio_i come
// from the pad and are brought into the clk domain through a 2-flop
// synchronizer. The FSM samples on synchronized rising edges and changes what
// it drives on synchronized falling edges. clk must run at 4x swclk or faster
// so that each swclk phase spans several clk cycles.
//
// Ports
//   clk, rst_n     system clock; synchronous active-low reset
//   swclk          SWD clock from the host (asynchronous to clk)
//   swdio_i        SWDIO pad input
//   swdio_o        SWDIO pad output value (0 whenever swdio_oe = 0)
//   swdio_oe       SWDIO pad output enable (1 = target drives)
//   ack_sel        ACK to return, sent LSB first (001 OK, 010 WAIT, 100 FAULT)
//   ack_sel_vld    1 = use ack_sel, 0 = use ACK_DEFAULT
//   rd_data        read data returned on OK reads
//   req_valid      one-clk pulse: a valid request was decoded
//   req_apndp      decoded APnDP, held until the next req_valid
//   req_rnw        decoded RnW, held until the next req_valid
//   req_addr       decoded {A3,A2}, held until the next req_valid
//   wr_valid       one-clk pulse: write data and parity captured
//   wr_data        captured write data, held until the next wr_valid
//   wr_parity_err  qualifies wr_valid; 1 = write parity mismatch
//   proto_err      one-clk pulse: malformed request
// -----------------------------------------------------------------------------
module swd_target_responder #(
  parameter logic [2:0] ACK_DEFAULT = 3'b001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        swclk,
  input  logic        swdio_i,
  output logic        swdio_o,
  output logic        swdio_oe,
  input  logic [2:0]  ack_sel,
  input  logic        ack_sel_vld,
  input  logic [31:0] rd_data,
  output logic        req_valid,
  output logic        req_apndp,
  output logic        req_rnw,
  output logic [1:0]  req_addr,
  output logic        wr_valid,
  output logic [31:0] wr_data,
  output logic        wr_parity_err,
  output logic        proto_err
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_TRN1  = 3'd2,
    ST_ACK   = 3'd3,
    ST_RDATA = 3'd4,
    ST_TRN2  = 3'd5,
    ST_WDATA = 3'd6
  } state_t;

  // Even parity (XOR reduction) of a 32-bit data word.
  function automatic logic par32(input logic [31:0] v);
    return ^v;
  endfunction

  // Even parity of the four request header bits {A3,A2,RnW,APnDP}.
  function automatic logic par4(input logic [3:0] v);
    return ^v;
  endfunction

  // Synchronizer and edge-detection state.
  logic swclk_s1_q, swclk_s2_q, swclk_prev_q;
  logic swdio_s1_q, swdio_s2_q;
  logic rise_evt, fall_evt;

  // FSM state and datapath registers.
  state_t      state_q;
  logic [5:0]  bit_cnt_q;
  logic [5:0]  req_bits_q;   // APnDP, RnW, A2, A3, parity, stop (LSB first)
  logic [2:0]  ack_q;
  logic [31:0] rd_q;
  logic        rd_par_q;
  logic [31:0] wr_shift_q;

  // Registered outputs.
  logic        swdio_o_q, swdio_oe_q;
  logic        req_valid_q, req_apndp_q, req_rnw_q;
  logic [1:0]  req_addr_q;
  logic        wr_valid_q, wr_parity_err_q, proto_err_q;
  logic [31:0] wr_data_q;

  // Combinational helpers.
  logic        req_ok_d;
  logic [4:0]  rd_idx_d;

  assign rise_evt = swclk_s2_q & ~swclk_prev_q;
  assign fall_evt = ~swclk_s2_q & swclk_prev_q;

  // Request check (park is the bit being sampled) and next read-bit index.
  always_comb begin
    req_ok_d = (req_bits_q[4] == par4(req_bits_q[3:0])) && !req_bits_q[5] && swdio_s2_q;
    rd_idx_d = bit_cnt_q[4:0] + 5'd1;
  end

  // Two-flop synchronizers for swclk and swdio_i, plus the previous swclk value
  // used for edge detection. swdio goes through the same depth so that data
  // stays aligned with the clock edge that qualifies it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      swclk_s1_q   <= 1'b0;
      swclk_s2_q   <= 1'b0;
      swclk_prev_q <= 1'b0;
      swdio_s1_q   <= 1'b0;
      swdio_s2_q   <= 1'b0;
    end else begin
      swclk_s1_q   <= swclk;
      swclk_s2_q   <= swclk_s1_q;
      swclk_prev_q <= swclk_s2_q;
      swdio_s1_q   <= swdio_i;
      swdio_s2_q   <= swdio_s1_q;
    end
  end

  // Protocol FSM with registered pad and handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      bit_cnt_q       <= 6'd0;
      req_bits_q      <= 6'd0;
      ack_q           <= 3'd0;
      rd_q            <= 32'd0;
      rd_par_q        <= 1'b0;
      wr_shift_q      <= 32'd0;
      swdio_o_q       <= 1'b0;
      swdio_oe_q      <= 1'b0;
      req_valid_q     <= 1'b0;
      req_apndp_q     <= 1'b0;
      req_rnw_q       <= 1'b0;
      req_addr_q      <= 2'd0;
      wr_valid_q      <= 1'b0;
      wr_data_q       <= 32'd0;
      wr_parity_err_q <= 1'b0;
      proto_err_q     <= 1'b0;
    end else begin
      req_valid_q <= 1'b0;
      wr_valid_q  <= 1'b0;
      proto_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          swdio_oe_q <= 1'b0;
          swdio_o_q  <= 1'b0;
          if (rise_evt && swdio_s2_q) begin
            state_q   <= ST_REQ;
            bit_cnt_q <= 6'd0;
          end
        end

        ST_REQ: begin
          if (rise_evt) begin
            if (bit_cnt_q == 6'd6) begin
              bit_cnt_q <= 6'd0;
              if (req_ok_d) begin
                req_valid_q <= 1'b1;
                req_apndp_q <= req_bits_q[0];
                req_rnw_q   <= req_bits_q[1];
                req_addr_q  <= {req_bits_q[3], req_bits_q[2]};
                ack_q       <= ack_sel_vld ? ack_sel : ACK_DEFAULT;
                state_q     <= ST_TRN1;
              end else begin
                proto_err_q <= 1'b1;
                state_q     <= ST_IDLE;
              end
            end else begin
              req_bits_q[bit_cnt_q[2:0]] <= swdio_s2_q;
              bit_cnt_q                  <= bit_cnt_q + 6'd1;
            end
          end
        end

        // First falling edge is the host releasing the line; the next one
        // starts the ACK.
        ST_TRN1: begin
          if (fall_evt) begin
            if (bit_cnt_q == 6'd0) begin
              bit_cnt_q <= 6'd1;
            end else begin
              swdio_oe_q <= 1'b1;
              swdio_o_q  <= ack_q[0];
              bit_cnt_q  <= 6'd0;
              state_q    <= ST_ACK;
            end
          end
        end

        ST_ACK: begin
          if (fall_evt) begin
            case (bit_cnt_q)
              6'd0: begin
                swdio_o_q <= ack_q[1];
                bit_cnt_q <= 6'd1;
              end
              6'd1: begin
                // Snapshot read data so it cannot change mid-transfer.
                swdio_o_q <= ack_q[2];
                rd_q      <= rd_data;
                rd_par_q  <= par32(rd_data);
                bit_cnt_q <= 6'd2;
              end
              default: begin
                bit_cnt_q <= 6'd0;
                if ((ack_q == 3'b001) && req_rnw_q) begin
                  swdio_o_q <= rd_q[0];
                  state_q   <= ST_RDATA;
                end else if (ack_q == 3'b001) begin
                  swdio_oe_q <= 1'b0;
                  swdio_o_q  <= 1'b0;
                  state_q    <= ST_TRN2;
                end else begin
                  swdio_oe_q <= 1'b0;
                  swdio_o_q  <= 1'b0;
                  state_q    <= ST_IDLE;
                end
              end
            endcase
          end
        end

        // bit_cnt_q holds the index of the bit currently on the wire; 32 means
        // parity is on the wire.
        ST_RDATA: begin
          if (fall_evt) begin
            if (bit_cnt_q < 6'd31) begin
              swdio_o_q <= rd_q[rd_idx_d];
              bit_cnt_q <= bit_cnt_q + 6'd1;
            end else if (bit_cnt_q == 6'd31) begin
              swdio_o_q <= rd_par_q;
              bit_cnt_q <= 6'd32;
            end else begin
              swdio_oe_q <= 1'b0;
              swdio_o_q  <= 1'b0;
              bit_cnt_q  <= 6'd0;
              state_q    <= ST_IDLE;
            end
          end
        end

        // The turnaround rising edge carries no data.
        ST_TRN2: begin
          if (rise_evt) begin
            bit_cnt_q <= 6'd0;
            state_q   <= ST_WDATA;
          end
        end

        ST_WDATA: begin
          if (rise_evt) begin
            if (bit_cnt_q < 6'd32) begin
              wr_shift_q[bit_cnt_q[4:0]] <= swdio_s2_q;
              bit_cnt_q                  <= bit_cnt_q + 6'd1;
            end else begin
              wr_valid_q      <= 1'b1;
              wr_data_q       <= wr_shift_q;
              wr_parity_err_q <= swdio_s2_q ^ par32(wr_shift_q);
              bit_cnt_q       <= 6'd0;
              state_q         <= ST_IDLE;
            end
          end
        end

        default: begin
          swdio_oe_q <= 1'b0;
          swdio_o_q  <= 1'b0;
          bit_cnt_q  <= 6'd0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign swdio_o       = swdio_o_q;
  assign swdio_oe      = swdio_oe_q;
  assign req_valid     = req_valid_q;
  assign req_apndp     = req_apndp_q;
  assign req_rnw       = req_rnw_q;
  assign req_addr      = req_addr_q;
  assign wr_valid      = wr_valid_q;
  assign wr_data       = wr_data_q;
  assign wr_parity_err = wr_parity_err_q;
  assign proto_err     = proto_err_q;

endmodule

// File: tb/tb_swd_target_responder.sv
// -----------------------------------------------------------------------------
// tb_swd_target_responder
//
// Acts as the SWD host: it drives swclk/swdio_i from a plain bit-level model
// and computes the expected wire response and handshake outputs from the
// request fields, the selected ACK and the data words.
// -----------------------------------------------------------------------------
module tb_swd_target_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        swclk = 1'b1;
  logic        swdio_i = 1'b0;
  logic        swdio_o, swdio_oe;
  logic [2:0]  ack_sel = 3'b001;
  logic        ack_sel_vld = 1'b1;
  logic [31:0] rd_data = 32'd0;
  logic        req_valid, req_apndp, req_rnw;
  logic [1:0]  req_addr;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic        wr_parity_err, proto_err;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Pulse counters and values captured at each pulse.
  int          n_req = 0;
  int          n_wr = 0;
  int          n_proto = 0;
  logic [3:0]  last_req = 4'd0;
  logic [31:0] last_wdata = 32'd0;
  logic        last_werr = 1'b0;

  swd_target_responder #(.ACK_DEFAULT(3'b001)) dut (
    .clk(clk), .rst_n(rst_n), .swclk(swclk), .swdio_i(swdio_i),
    .swdio_o(swdio_o), .swdio_oe(swdio_oe),
    .ack_sel(ack_sel), .ack_sel_vld(ack_sel_vld), .rd_data(rd_data),
    .req_valid(req_valid), .req_apndp(req_apndp), .req_rnw(req_rnw),
    .req_addr(req_addr), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_parity_err(wr_parity_err), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  // Count pulses (a pulse held for two clks counts twice) and capture fields.
  always @(negedge clk) begin
    if (req_valid) begin
      n_req    = n_req + 1;
      last_req = {req_apndp, req_rnw, req_addr};
    end
    if (wr_valid) begin
      n_wr       = n_wr + 1;
      last_wdata = wr_data;
      last_werr  = wr_parity_err;
    end
    if (proto_err) n_proto = n_proto + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One host swclk cycle: fall, drive, observe pad just before the rise.
  task automatic swd_cyc(input logic drv, output logic [1:0] obs);
    swclk   = 1'b0;
    swdio_i = drv;
    #50;
    obs   = {swdio_oe, swdio_o};
    swclk = 1'b1;
    #50;
  endtask

  // One complete transaction. rst_bit >= 0 asserts reset while that read-data
  // bit is on the wire and abandons the frame.
  task automatic frame(input logic [7:0] req, input logic [2:0] ack, input logic vld,
                       input logic [31:0] rdata, input logic [31:0] wdata,
                       input logic wpar, input int rst_bit);
    logic [1:0] o;
    logic       apndp, rnw, a2, a3, ok;
    logic [2:0] a;
    int         req0, wr0, pe0;
    req0 = n_req; wr0 = n_wr; pe0 = n_proto;
    ack_sel = ack; ack_sel_vld = vld; rd_data = rdata;
    for (int i = 0; i < 8; i++) begin
      swd_cyc(req[i], o);
      check("req_phase_pad", {30'd0, o}, 32'd0);
    end
    apndp = req[1]; rnw = req[2]; a2 = req[3]; a3 = req[4];
    ok = (req[5] == (apndp ^ rnw ^ a2 ^ a3)) && (req[6] == 1'b0) && (req[7] == 1'b1);
    if (!ok) begin
      check("proto_err_pulse", n_proto, pe0 + 1);
      check("no_req_valid", n_req, req0);
      swd_cyc(1'b0, o);
      check("proto_pad_idle", {30'd0, o}, 32'd0);
    end else begin
      check("req_valid_pulse", n_req, req0 + 1);
      check("req_fields", {28'd0, last_req}, {28'd0, apndp, rnw, a3, a2});
      check("no_proto_err", n_proto, pe0);
      a = vld ? ack : 3'b001;
      swd_cyc(1'b0, o);
      check("trn1_pad", {30'd0, o}, 32'd0);
      for (int i = 0; i < 3; i++) begin
        swd_cyc(1'b0, o);
        check("ack_bit", {30'd0, o}, {30'd0, 1'b1, a[i]});
      end
      if (a == 3'b001 && rnw) begin
        for (int i = 0; i < 32; i++) begin
          if (i == rst_bit) begin
            swclk = 1'b0; swdio_i = 1'b0;
            #40;
            check("pre_reset_drive", {30'd0, swdio_oe, swdio_o}, {30'd0, 1'b1, rdata[i]});
            rst_n = 1'b0;
            @(posedge clk); #1;
            check("reset_pad", {30'd0, swdio_oe, swdio_o}, 32'd0);
            check("reset_fields", {27'd0, req_valid, req_apndp, req_rnw, req_addr},
                  32'd0);
            check("reset_wr", {wr_data[31:1], wr_data[0] | wr_parity_err | wr_valid | proto_err},
                  32'd0);
            repeat (2) @(posedge clk);
            #5;
            rst_n = 1'b1;
            swclk = 1'b1;
            #50;
            return;
          end
          swd_cyc(1'b0, o);
          check("rdata_bit", {30'd0, o}, {30'd0, 1'b1, rdata[i]});
        end
        swd_cyc(1'b0, o);
        check("rdata_parity", {30'd0, o}, {30'd0, 1'b1, ($countones(rdata) % 2 == 1)});
        swd_cyc(1'b0, o);
        check("read_release", {30'd0, o}, 32'd0);
      end else if (a == 3'b001) begin
        swd_cyc(1'b0, o);
        check("trn2_pad", {30'd0, o}, 32'd0);
        for (int i = 0; i < 32; i++) begin
          swd_cyc(wdata[i], o);
          check("wdata_pad", {30'd0, o}, 32'd0);
        end
        swd_cyc(wpar, o);
        check("wr_valid_pulse", n_wr, wr0 + 1);
        check("wr_data", last_wdata, wdata);
        check("wr_parity_err", {31'd0, last_werr},
              {31'd0, wpar != ($countones(wdata) % 2 == 1)});
      end else begin
        swd_cyc(1'b0, o);
        check("nonok_release", {30'd0, o}, 32'd0);
        check("nonok_no_wr", n_wr, wr0);
      end
    end
    repeat (3) swd_cyc(1'b0, o);
  endtask

  initial begin
    logic [7:0]  rq;
    logic [2:0]  ak;
    logic [31:0] r;
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_pad", {30'd0, swdio_oe, swdio_o}, 32'd0);
    check("rst_pulses", {29'd0, req_valid, wr_valid, proto_err}, 32'd0);
    check("rst_req_fields", {28'd0, req_apndp, req_rnw, req_addr}, 32'd0);
    check("rst_wr", {31'd0, wr_parity_err}, 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Directed scenarios.
    frame(8'hA5, 3'b001, 1'b1, 32'h12345678, 32'd0, 1'b0, -1);          // read OK
    frame(8'hA5, 3'b010, 1'b1, $urandom, 32'd0, 1'b0, -1);              // read WAIT
    frame(8'h81, 3'b001, 1'b1, 32'd0, 32'hDEADBEEF, 1'b0, -1);          // write OK
    frame(8'h81, 3'b001, 1'b1, 32'd0, 32'hDEADBEEF, 1'b1, -1);          // write bad parity
    frame(8'h85, 3'b001, 1'b1, 32'd0, 32'd0, 1'b0, -1);                 // request parity error
    frame(8'hA5, 3'b001, 1'b1, $urandom, 32'd0, 1'b0, -1);              // served normally
    frame(8'hA5, 3'b001, 1'b1, $urandom, 32'd0, 1'b0, 10);              // reset mid-read
    frame(8'hA5, 3'b001, 1'b1, $urandom, 32'd0, 1'b0, -1);              // read after reset
    frame(8'hA5, 3'b100, 1'b0, $urandom, 32'd0, 1'b0, -1);              // ACK_DEFAULT used
    frame(8'h81, 3'b100, 1'b1, 32'd0, $urandom, 1'b0, -1);              // write FAULT

    // Randomized frames.
    for (int n = 0; n < 10; n++) begin
      rq[0] = 1'b1;
      rq[4:1] = 4'($urandom_range(0, 15));
      rq[5] = ^rq[4:1];
      rq[6] = 1'b0;
      rq[7] = 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        r = 32'($urandom_range(5, 7));
        rq[r[2:0]] = ~rq[r[2:0]];
      end
      case ($urandom_range(0, 3))
        0: ak = 3'b010;
        1: ak = 3'b100;
        2: ak = 3'($urandom_range(0, 7));
        default: ak = 3'b001;
      endcase
      frame(rq, ak, 1'($urandom_range(0, 1)), $urandom, $urandom,
            1'($urandom_range(0, 1)), -1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/swd_target_responder.md
SWD_TARGET_RESPONDER -- requirements
Module: swd_target_responder

Interface
REQ-001 SHALL have parameter ACK_DEFAULT, default 3'b001, meaning ACK driven when ack_sel_vld=0.
REQ-002 SHALL have port clk  in  1  system clock; ≥4x SWCLK frequency.
REQ-003 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port swclk  in  1  SWD clock from host; asynchronous to clk.
REQ-005 SHALL have port swdio_i  in  1  SWDIO pad input.
REQ-006 SHALL have port swdio_o  out  1  SWDIO pad output value.
REQ-007 SHALL have port swdio_oe  out  1  SWDIO pad output enable; 1 = target drives.
REQ-008 SHALL have port ack_sel  in  3  ACK to return, LSB-first on wire (001 OK, 010 WAIT, 100 FAULT).
REQ-009 SHALL have port ack_sel_vld  in  1  1 = use ack_sel, 0 = use ACK_DEFAULT.
REQ-010 SHALL have port rd_data  in  32  read data returned on OK reads.
REQ-011 SHALL have port req_valid  out  1  one-clk pulse: valid request decoded.
REQ-012 SHALL have port req_apndp, req_rnw  out  1 each  decoded request fields, held until next req_valid.
REQ-013 SHALL have port req_addr  out  2  decoded {A3,A2}, held until next req_valid.
REQ-014 SHALL have port wr_valid  out  1  one-clk pulse: write data and parity captured.
REQ-015 SHALL have port wr_data  out  32  captured write data, held until next wr_valid.
REQ-016 SHALL have port wr_parity_err  out  1  qualifies wr_valid; 1 = parity mismatch.
REQ-017 SHALL have port proto_err  out  1  one-clk pulse: malformed request.

Function
REQ-018 SHALL synchronize swclk through 2 flops and derive one-clk rise_evt and fall_evt pulses from it; all sampling occurs on rise_evt and all drive changes on fall_evt.
REQ-019 SHALL sample swdio_i through the same 2-flop delay as swclk.
REQ-020 SHALL implement FSM states IDLE, REQ, TRN1, ACK, RDATA, TRN2, WDATA; no other states.
REQ-021 In IDLE, a rise_evt with swdio_i=1 (start bit) SHALL move the FSM to REQ; 0 SHALL keep it in IDLE.
REQ-022 REQ SHALL shift 7 further bits LSB-first: APnDP, RnW, A2, A3, parity, stop, park.
REQ-023 The request SHALL be valid iff parity = APnDP^RnW^A2^A3, stop = 0, and park = 1.
REQ-024 A valid request SHALL pulse req_valid one clk after the park rise_evt, latch the ACK selection, and enter TRN1.
REQ-025 An invalid request SHALL pulse proto_err, keep swdio_oe=0, and return to IDLE.
REQ-026 TRN1 SHALL ignore the first fall_evt and the turnaround rise_evt, then on the next fall_evt assert swdio_oe=1, drive ACK[0], and enter ACK.
REQ-027 ACK SHALL drive ACK[1] and ACK[2] on the two subsequent fall_evt.
REQ-028 Read with ACK=001: after ACK[2], the next 32 fall_evt SHALL drive rd_data[0..31] and the following fall_evt SHALL drive parity = ^rd_data (RDATA).
REQ-029 rd_data SHALL be captured on the ACK[2] fall_evt and SHALL remain stable for the data phase.
REQ-030 At the fall_evt after read parity, swdio_oe SHALL go 0 and the FSM SHALL go to IDLE.
REQ-031 Write with ACK=001: the fall_evt after ACK[2] SHALL set swdio_oe=0 (TRN2); the next rise_evt (turnaround) SHALL be ignored.
REQ-032 WDATA SHALL sample 32 data bits LSB-first and then 1 parity bit on successive rise_evt.
REQ-033 Once WDATA sampling completes, the block SHALL pulse wr_valid one clk after the parity rise_evt, with wr_parity_err = (parity != ^data), and SHALL return to IDLE.
REQ-034 Non-OK ACK (any value ≠001): the fall_evt after ACK[2] SHALL set swdio_oe=0 and the FSM SHALL go to IDLE; no data phase occurs.
REQ-035 Bit counter SHALL be 6-bit, clear on every state entry, and never wrap within a state.
REQ-036 swdio_o SHALL be 0 whenever swdio_oe=0.

Reset
REQ-037 rst_n=0 at any clk edge, including mid-frame, SHALL force FSM=IDLE and synchronizer flops to 0.
REQ-038 rst_n=0 SHALL force swdio_oe=0, swdio_o=0, all pulse outputs 0, and req_*/wr_data/wr_parity_err to 0.
REQ-039 After reset, the first rise_evt SHALL be evaluated only after 2 clk with rst_n=1.

Verification
REQ-040 Read OK: request 0xA5, ack_sel=001, rd_data=0x12345678 -> req_valid (apndp=0, rnw=1, addr=0); wire shows ACK 1,0,0, data LSB-first, parity 1; oe=0 after parity.
REQ-041 Read WAIT: request 0xA5, ack_sel=010 -> wire shows ACK 0,1,0; oe drops at the next fall_evt; no data driven.
REQ-042 Write OK: request 0x81, data 0xDEADBEEF, parity 0 -> wr_valid=1, wr_data=0xDEADBEEF, wr_parity_err=0; oe=1 only during the 3 ACK bits.
REQ-043 Write bad parity: same as REQ-042 but parity 1 -> wr_valid=1, wr_parity_err=1.
REQ-044 Request parity error: 0x85 -> proto_err pulse, swdio_oe stays 0, next valid 0xA5 is served normally.
REQ-045 Reset mid-read: rst_n=0 during data bit 10 -> oe=0 next clk, FSM=IDLE; subsequent 0xA5 read completes correctly.
